// File: rtl/nn_pkg.sv
// Shared fixed-point constants, sequencer states and weight-ROM addressing
// for the neural-network layer blocks.
package nn_pkg;
    localparam int WIDTH = 32;
    localparam int FBITS = 24;
    localparam logic [WIDTH-1:0] Q_ONE = 32'h0100_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_ACT,
        S_OUT
    } state_e;

    // Row-major ROM layout: N_IN weights then the bias for each neuron.
    function automatic int unsigned wgt_addr(input int unsigned n,
                                             input int unsigned k,
                                             input int unsigned n_in);
        return n * (n_in + 1) + k;
    endfunction
endpackage

// File: rtl/mult_Q.sv
// Signed fixed-point multiplier: full-width product shifted right by FBITS
// (floor toward minus infinity), low WIDTH bits kept.
module mult_Q #(
    parameter int WIDTH = 32,
    parameter int FBITS = 24
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    logic signed [2*WIDTH-1:0] prod;

    assign prod = (2*WIDTH)'($signed(a)) * (2*WIDTH)'($signed(b));
    assign y    = WIDTH'(prod >>> FBITS);
endmodule

// File: rtl/nn_mac_acc.sv
// Latched input vector, one-deep pending-read register, operand mux and
// wrapping accumulator for the shared-multiplier layer sequencer.
module nn_mac_acc #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 2,
    parameter int K_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_x,
    input  logic [N_IN*WIDTH-1:0] x_flat,
    input  logic                  clr_acc,
    input  logic                  rd_issue,
    input  logic [K_W-1:0]        rd_idx,
    input  logic [WIDTH-1:0]      w_data,
    input  logic [WIDTH-1:0]      mac_y,
    output logic [WIDTH-1:0]      mac_a,
    output logic [WIDTH-1:0]      mac_b,
    output logic [WIDTH-1:0]      acc
);
    logic [N_IN-1:0][WIDTH-1:0] x_q;
    logic                       pend_q;
    logic [K_W-1:0]             pidx_q;
    logic [WIDTH-1:0]           acc_q, acc_d;
    logic                       is_mul, is_bias;

    assign is_mul  = pend_q && (pidx_q <  K_W'(N_IN));
    assign is_bias = pend_q && (pidx_q == K_W'(N_IN));

    // Operands are forced to zero unless a weight read is being consumed.
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        if (is_mul) begin
            mac_b = w_data;
            for (int i = 0; i < N_IN; i++) begin
                if (pidx_q == K_W'(i)) mac_a = x_q[i];
            end
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (clr_acc)      acc_d = '0;
        else if (is_mul)  acc_d = acc_q + mac_y;
        else if (is_bias) acc_d = acc_q + w_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q    <= '0;
            pend_q <= 1'b0;
            pidx_q <= '0;
            acc_q  <= '0;
        end else begin
            if (load_x) x_q <= x_flat;
            pend_q <= rd_issue;
            pidx_q <= rd_idx;
            acc_q  <= acc_d;
        end
    end

    assign acc = acc_q;
endmodule

// File: rtl/layer_seq_ctrl.sv
// Time-multiplexes one multiplier and one activation unit over every neuron
// of a fully connected layer; results leave on a valid/ready stream.
module layer_seq_ctrl #(
    parameter int WIDTH  = nn_pkg::WIDTH,
    parameter int FBITS  = nn_pkg::FBITS,
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2,
    parameter int ADDR_W = 8
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic [N_IN*WIDTH-1:0]                      x_flat,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       w_rd,
    output logic [ADDR_W-1:0]                          w_addr,
    input  logic [WIDTH-1:0]                           w_data,
    output logic [WIDTH-1:0]                           mac_a,
    output logic [WIDTH-1:0]                           mac_b,
    input  logic [WIDTH-1:0]                           mac_y,
    output logic [WIDTH-1:0]                           act_in,
    input  logic [WIDTH-1:0]                           act_y,
    output logic                                       y_valid,
    input  logic                                       y_ready,
    output logic [WIDTH-1:0]                           y_data,
    output logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] y_idx
);
    import nn_pkg::*;

    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int K_W   = (N_IN > 0) ? $clog2(N_IN + 1) : 1;

    if (((1 << ADDR_W) < N_OUT * (N_IN + 1)) || (FBITS >= WIDTH)) begin : g_bad_cfg
        $error("layer_seq_ctrl: ROM address space or fraction width out of range");
    end

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  n_q, n_d;
    logic [K_W-1:0]    k_q, k_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              y_valid_q, y_valid_d;
    logic [WIDTH-1:0]  y_data_q, y_data_d;
    logic [IDX_W-1:0]  y_idx_q, y_idx_d;
    logic              load_x, clr_acc;
    logic [WIDTH-1:0]  acc;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        k_d       = k_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        y_valid_d = y_valid_q;
        y_data_d  = y_data_q;
        y_idx_d   = y_idx_q;
        load_x    = 1'b0;
        clr_acc   = 1'b0;
        w_rd      = 1'b0;
        w_addr    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_x  = 1'b1;
                    clr_acc = 1'b1;
                    n_d     = '0;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                w_rd   = 1'b1;
                w_addr = ADDR_W'(wgt_addr(32'(n_q), 32'(k_q), N_IN));
                if (k_q == K_W'(N_IN)) state_d = S_DRAIN;
                else                   k_d     = k_q + K_W'(1);
            end
            // The bias read issued last in MAC is absorbed here.
            S_DRAIN: state_d = S_ACT;
            S_ACT: begin
                y_data_d  = act_y;
                y_idx_d   = n_q;
                y_valid_d = 1'b1;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (y_ready) begin
                    y_valid_d = 1'b0;
                    if (n_q == IDX_W'(N_OUT - 1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        n_d     = n_q + IDX_W'(1);
                        k_d     = '0;
                        clr_acc = 1'b1;
                        state_d = S_MAC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            k_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            y_idx_q   <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            k_q       <= k_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
            y_idx_q   <= y_idx_d;
        end
    end

    nn_mac_acc #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN),
        .K_W   (K_W)
    ) u_mac_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_x   (load_x),
        .x_flat   (x_flat),
        .clr_acc  (clr_acc),
        .rd_issue (w_rd),
        .rd_idx   (k_q),
        .w_data   (w_data),
        .mac_y    (mac_y),
        .mac_a    (mac_a),
        .mac_b    (mac_b),
        .acc      (acc)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign y_idx   = y_idx_q;
    assign act_in  = acc;
endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Bench for layer_seq_ctrl: real multiplier, identity activation, 1-cycle ROM.
module tb_layer_seq_ctrl;
    localparam int WIDTH = 32, FBITS = 24, N_IN = 2, N_OUT = 2, ADDR_W = 8;
    localparam logic [31:0] Q1 = nn_pkg::Q_ONE;

    logic                  clk = 1'b0, rst_n = 1'b0, start = 1'b0, y_ready = 1'b0;
    logic [N_IN*WIDTH-1:0] x_flat = '0;
    logic                  busy, done, w_rd, y_valid;
    logic [ADDR_W-1:0]     w_addr;
    logic [WIDTH-1:0]      w_data = '0, mac_a, mac_b, mac_y, act_in, act_y, y_data;
    logic [0:0]            y_idx;

    always #5 clk = ~clk;

    layer_seq_ctrl #(.WIDTH(WIDTH), .FBITS(FBITS), .N_IN(N_IN), .N_OUT(N_OUT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_flat(x_flat), .busy(busy), .done(done),
        .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data), .mac_a(mac_a), .mac_b(mac_b), .mac_y(mac_y),
        .act_in(act_in), .act_y(act_y), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
        .y_idx(y_idx)
    );

    mult_Q #(.WIDTH(WIDTH), .FBITS(FBITS)) u_mul (.a(mac_a), .b(mac_b), .y(mac_y));
    assign act_y = act_in;

    logic [31:0] rom [0:255];
    always @(posedge clk) if (w_rd) w_data <= rom[w_addr];

    int errs = 0, chks = 0;
    int addr_q[$];
    logic [31:0] got_y[2];
    logic [0:0]  got_idx[2];
    int rise[2], hs_edge[2];
    int nres, ndone, done_edge;

    typedef struct {
        logic [31:0] x0, x1;
        logic [31:0] w[6];
        logic [31:0] e0, e1;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_rom(input logic [31:0] w[6]);
        for (int i = 0; i < 256; i++) rom[i] = '0;
        for (int i = 0; i < 6; i++) rom[i] = w[i];
    endtask

    // Layer result from the arithmetic rules: floor-shifted products plus bias, 32-bit wrap.
    function automatic logic [31:0] ref_neuron(input int n, input logic [31:0] x0, input logic [31:0] x1);
        longint s;
        logic [31:0] xs[2];
        xs[0] = x0;
        xs[1] = x1;
        s = 0;
        for (int i = 0; i < N_IN; i++)
            s += (longint'($signed(xs[i])) * longint'($signed(rom[n*(N_IN+1)+i]))) >>> FBITS;
        s += longint'($signed(rom[n*(N_IN+1)+N_IN]));
        return s[31:0];
    endfunction

    task automatic run_pass(input logic [31:0] x0, input logic [31:0] x1, input int bp, input bit busy_start);
        int cyc, vcnt;
        bit prev_v;
        logic [31:0] hd;
        logic [0:0] hi;
        addr_q.delete();
        nres = 0; ndone = 0; done_edge = -1;
        rise[0] = -1; rise[1] = -1; hs_edge[0] = -1; hs_edge[1] = -1;
        vcnt = 0; prev_v = 0; hd = '0; hi = '0;
        @(negedge clk);
        x_flat = {x1, x0};
        start = 1'b1;
        y_ready = (bp == 0);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        check("busy_after_start", busy, 1);
        while (cyc < 300 && ndone == 0) begin
            if (w_rd) addr_q.push_back(int'(w_addr));
            if (done) begin
                ndone++;
                done_edge = cyc;
                check("busy_low_at_done", busy, 0);
            end
            if (y_valid) begin
                if (!prev_v) begin
                    if (nres < 2) rise[nres] = cyc;
                    vcnt = 0; hd = y_data; hi = y_idx;
                end else begin
                    check("y_data_stable", y_data, hd);
                    check("y_idx_stable", y_idx, hi);
                end
                check("no_rd_in_out", w_rd, 0);
                vcnt++;
                y_ready = (vcnt > bp);
                if (y_ready && nres < 2) begin
                    got_y[nres] = y_data;
                    got_idx[nres] = y_idx;
                    hs_edge[nres] = cyc + 1;
                    nres++;
                end
            end else begin
                y_ready = (bp == 0);
            end
            prev_v = y_valid;
            start = busy_start && (cyc == 1);
            if (start) x_flat = {32'h0300_0000, 32'h0040_0000};
            @(negedge clk);
            cyc++;
        end
        check("pass_done_seen", ndone, 1);
        start = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_not_busy", busy, 0);
        y_ready = 1'b0;
    endtask

    task automatic check_pass(input string tag, input logic [31:0] e0, input logic [31:0] e1);
        check({tag, "_nres"}, nres, 2);
        check({tag, "_naddr"}, addr_q.size(), 6);
        for (int i = 0; i < 6 && i < addr_q.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), addr_q[i], i);
        check({tag, "_y0"}, got_y[0], e0);
        check({tag, "_idx0"}, got_idx[0], 0);
        check({tag, "_y1"}, got_y[1], e1);
        check({tag, "_idx1"}, got_idx[1], 1);
        check({tag, "_rise0"}, rise[0], 5);
        check({tag, "_rise1"}, rise[1], hs_edge[0] + N_IN + 3);
        check({tag, "_done_edge"}, done_edge, hs_edge[1]);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_w_rd"}, w_rd, 0);
        check({tag, "_w_addr"}, w_addr, 0);
        check({tag, "_y_valid"}, y_valid, 0);
        check({tag, "_y_data"}, y_data, 0);
        check({tag, "_y_idx"}, y_idx, 0);
        check({tag, "_act_in"}, act_in, 0);
        check({tag, "_mac_a"}, mac_a, 0);
        check({tag, "_mac_b"}, mac_b, 0);
    endtask

    logic [31:0] basic_w[6];

    initial begin
        basic_w = '{32'h0080_0000, 32'h0080_0000, 32'h0, Q1, 32'hFF80_0000, Q1};

        tbl[0].x0 = Q1;            tbl[0].x1 = 32'h0080_0000; tbl[0].w = basic_w;
        tbl[0].e0 = 32'h00C0_0000; tbl[0].e1 = 32'h01C0_0000;
        tbl[1].x0 = 32'h7F00_0000; tbl[1].x1 = 32'h7F00_0000;
        tbl[1].w  = '{Q1, Q1, 32'h0, 32'h0, 32'h0, 32'h0012_3456};
        tbl[1].e0 = 32'hFE00_0000; tbl[1].e1 = 32'h0012_3456;
        tbl[2].x0 = 32'hFF00_0000; tbl[2].x1 = 32'h0200_0000;
        tbl[2].w  = '{32'h0040_0000, 32'hFE00_0000, 32'h0010_0000, Q1, Q1, 32'hFF00_0000};
        tbl[2].e0 = 32'hFBD0_0000; tbl[2].e1 = 32'h0;
        tbl[3].x0 = 32'hFFFF_FFFF; tbl[3].x1 = 32'h0000_0001;
        tbl[3].w  = '{32'h0080_0000, 32'h0080_0000, 32'h0, 32'h0, 32'h0, 32'h7FFF_FFFF};
        tbl[3].e0 = 32'hFFFF_FFFF; tbl[3].e1 = 32'h7FFF_FFFF;

        load_rom(basic_w);
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        for (int t = 0; t < 4; t++) begin
            load_rom(tbl[t].w);
            run_pass(tbl[t].x0, tbl[t].x1, 0, 1'b0);
            check_pass($sformatf("vec%0d", t), tbl[t].e0, tbl[t].e1);
        end

        load_rom(basic_w);
        run_pass(Q1, 32'h0080_0000, 7, 1'b0);
        check_pass("backpressure", 32'h00C0_0000, 32'h01C0_0000);

        run_pass(Q1, 32'h0080_0000, 0, 1'b1);
        check_pass("start_busy", 32'h00C0_0000, 32'h01C0_0000);

        // Reset while neuron 1 is fetching its weights.
        @(negedge clk);
        x_flat = {32'h0080_0000, Q1};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        y_ready = 1'b1;
        repeat (7) @(negedge clk);
        check("pre_reset_rd", w_rd, 1);
        check("pre_reset_addr", w_addr, 4);
        rst_n = 1'b0;
        y_ready = 1'b0;
        @(negedge clk);
        check_zero_outputs("midreset");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_idle_rd", w_rd, 0);
            check("post_reset_idle_busy", busy, 0);
        end
        run_pass(Q1, 32'h0080_0000, 0, 1'b0);
        check_pass("after_reset", 32'h00C0_0000, 32'h01C0_0000);

        for (int r = 0; r < 12; r++) begin
            logic [31:0] w[6];
            logic [31:0] x0, x1, e0, e1;
            for (int i = 0; i < 6; i++) w[i] = (r < 6) ? ($urandom >>> 4) ^ {{4{$urandom_range(0, 1) == 1}}, 28'h0} : $urandom;
            x0 = $urandom;
            x1 = $urandom;
            load_rom(w);
            e0 = ref_neuron(0, x0, x1);
            e1 = ref_neuron(1, x0, x1);
            run_pass(x0, x1, $urandom_range(0, 3), 1'b0);
            check_pass($sformatf("rand%0d", r), e0, e1);
        end

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule

// File: doc/layer_seq_ctrl.md
Name: layer_seq_ctrl

Overview:
Sequences one shared Q8.24 multiplier (mult_Q) and one tanh unit across all neurons of a fully connected layer.
- Per neuron, it fetches weights and bias from a synchronous weight ROM and accumulates the products.
- It applies the activation, then streams each neuron result out with a valid/ready handshake.
- It replaces per-neuron combinational datapaths in the MLP top level, trading latency for area.

Parameters:
WIDTH, 32, data word width (signed Q format)
FBITS, 24, fractional bits; passed through to the multiplier configuration
N_IN, 2, inputs per neuron
N_OUT, 2, neurons in the layer
ADDR_W, 8, weight ROM address width; must satisfy 2^ADDR_W >= N_OUT*(N_IN+1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin a layer pass; sampled only in IDLE
x_flat  in  N_IN*WIDTH  input vector; element i at bits [i*WIDTH +: WIDTH]; latched when start is accepted
busy  out  1  high from start acceptance until the done pulse
done  out  1  one-cycle pulse after the last neuron result is accepted
w_rd  out  1  ROM read strobe
w_addr  out  ADDR_W  ROM address = n*(N_IN+1)+k; k=N_IN selects the bias
w_data  in  WIDTH  ROM data, valid exactly 1 cycle after w_rd
mac_a  out  WIDTH  multiplier operand a (latched x element)
mac_b  out  WIDTH  multiplier operand b (= w_data)
mac_y  in  WIDTH  multiplier product, combinational from mac_a/mac_b
act_in  out  WIDTH  tanh input (= accumulator register)
act_y  in  WIDTH  tanh output, combinational from act_in
y_valid  out  1  result valid
y_ready  in  1  downstream ready
y_data  out  WIDTH  activated neuron output
y_idx  out  clog2(N_OUT) (min 1)  neuron index of y_data

Behaviour:
- Reset (rst_n=0 at a clock edge), including mid-operation:
  - state returns to IDLE; acc, n, k and the latched x are cleared.
  - All outputs return to 0: busy, done, w_rd, w_addr, y_valid, y_data, y_idx, act_in.
  - mac_a and mac_b are 0 whenever no read is pending.
- States: IDLE, MAC, DRAIN, ACT, OUT.
- IDLE:
  - On start=1: latch x_flat, set n=0, k=0, acc=0, busy=1, go to MAC.
  - Without start, or with start while busy, nothing happens; start is ignored in every other state.
- MAC:
  - Each cycle: w_rd=1, w_addr=n*(N_IN+1)+k, then k++.
  - After issuing k=N_IN (the bias address), go to DRAIN.
- Read pipeline:
  - A pending read (registered w_rd plus its index) is consumed the cycle after issue.
  - Index < N_IN: mac_a = x[idx], mac_b = w_data, and acc += mac_y.
  - Index == N_IN: acc += w_data (bias, no multiply).
- DRAIN: consume the final (bias) read, w_rd=0, go to ACT.
- ACT: y_data <= act_y (act_in = acc), y_idx <= n, y_valid <= 1, go to OUT.
- OUT:
  - y_valid, y_data and y_idx are held stable until y_valid & y_ready.
  - On that handshake, y_valid <= 0.
  - If n == N_OUT-1: done <= 1 for one cycle, busy <= 0, go to IDLE.
  - Otherwise: n++, k=0, acc=0, go to MAC in the next cycle. No bubble beyond the handshake cycle.
- Latency, counted in edges after start acceptance:
  - Addresses are issued after edges 0..N_IN.
  - y_valid rises at edge N_IN+3 (edge 5 for N_IN=2).
  - Each later neuron with y_ready=1 adds N_IN+4 cycles.
- Arithmetic:
  - acc is WIDTH bits, two's-complement wrap, no saturation; this matches the existing neuron adders.
  - Multiply rounding/truncation is owned entirely by mult_Q.
- w_addr is never issued beyond N_OUT*(N_IN+1)-1.

Decomposition:
- Shared package nn_pkg holds:
  - WIDTH=32 and FBITS=24.
  - Q_ONE = 32'h0100_0000.
  - The state enumeration constants.
  - A function wgt_addr(n,k,N_IN) returning n*(N_IN+1)+k.
- Optional sub-module nn_mac_acc holds the pending-read register, the operand mux and the accumulator. The FSM stays in layer_seq_ctrl.
- mult_Q and tanh remain outside, instantiated by the layer top.

Test Plan:
(Bench: real mult_Q instance, identity stub for tanh, ROM model with 1-cycle latency, N_IN=2, N_OUT=2. Neuron-0 ROM: addr 0, 1 = 0x00800000 (0.5 each), addr 2 = 0. Neuron-1 ROM: addr 3 = Q_ONE, addr 4 = 0xFF800000 (−0.5), addr 5 = Q_ONE.)
1. Basic pass: x=(Q_ONE, 0x00800000), start pulse, y_ready=1.
   - w_addr sequence is 0,1,2 then 3,4,5.
   - y0 = 0x00C00000 with y_idx=0, valid at edge 5.
   - y1 = 0x01C00000 with y_idx=1.
   - done pulses once, one cycle after the y1 handshake; busy falls on the same edge.
2. Backpressure: same stimulus with y_ready=0 for 7 cycles after y_valid.
   - y_valid/y_data/y_idx stay stable; no w_rd is issued while in OUT.
   - Results are identical to test 1 once ready is raised.
3. Start while busy: pulse start at edge 2 with a different x_flat.
   - The pulse is ignored; results equal test 1; exactly one done.
4. Reset mid-operation: assert rst_n=0 for 1 cycle during the neuron-1 MAC.
   - Next edge: all outputs are 0 and the state is IDLE.
   - A fresh start reproduces test 1 exactly.
5. Wrap: x=(0x7F000000, 0x7F000000), neuron-0 weights = Q_ONE, bias 0.
   - y0 = 0xFE000000 (wrapped two's-complement sum), no saturation.
